// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encoding, master indices and defaults for the data-memory arbiter
package dmem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;
    localparam int DEFAULT_DEPTH = 128;
    localparam int DEFAULT_MEM_LAT = 1;
endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick with a registered pointer naming the favoured master
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic       valid,
    output logic       idx
);
    logic ptr;
    always_comb begin
        valid = |req;
        idx   = &req ? ptr : (req[1] ? M1 : M0);
    end
    // Only contested grants move the pointer, so a lone requester never steals the next turn.
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= M0;
        else if (en && &req)
            ptr <= ~ptr;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter and fixed-latency sequencer for the single-port data memory
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    state_t        state;
    logic          win;
    logic [CW-1:0] cnt;
    logic          gnt_valid, gnt_idx;
    logic          sel_we, sel_err;
    logic [31:0]   sel_addr, sel_wdata;

    rr_arbiter2 u_rr (
        .clk  (clk),
        .reset(reset),
        .req  ({m1_req, m0_req}),
        .en   (state == IDLE),
        .valid(gnt_valid),
        .idx  (gnt_idx)
    );

    always_comb begin
        sel_we    = gnt_idx ? m1_we : m0_we;
        sel_addr  = gnt_idx ? m1_addr : m0_addr;
        sel_wdata = gnt_idx ? m1_wdata : m0_wdata;
        sel_err   = sel_addr >= 32'($unsigned(DEPTH));
    end

    // The strobes themselves remember read vs write for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            win       <= M0;
            cnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_done   <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_done   <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            m0_done <= 1'b0;
            m0_err  <= 1'b0;
            m1_done <= 1'b0;
            m1_err  <= 1'b0;
            case (state)
                IDLE: if (gnt_valid) begin
                    win <= gnt_idx;
                    if (sel_err) begin
                        state   <= RESP;
                        m0_done <= gnt_idx == M0;
                        m0_err  <= gnt_idx == M0;
                        m1_done <= gnt_idx == M1;
                        m1_err  <= gnt_idx == M1;
                    end else begin
                        state     <= ACCESS;
                        cnt       <= CW'(MEM_LAT - 1);
                        mem_read  <= !sel_we;
                        mem_write <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                    end
                end
                ACCESS: if (cnt == '0) begin
                    state     <= RESP;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    m0_done   <= win == M0;
                    m1_done   <= win == M1;
                    if (mem_read && win == M0)
                        m0_rdata <= mem_rdata;
                    if (mem_read && win == M1)
                        m1_rdata <= mem_rdata;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench driving a MEM_LAT=1 and a MEM_LAT=3 arbiter, each with its own memory model
module tb_dmem_arbiter;
    typedef struct {
        int          g;
        int          m;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk, reset, mem_load;
    logic        req[2][2], we[2][2], done[2][2], err[2][2];
    logic [31:0] addr[2][2], wdata[2][2], rdata[2][2];
    logic        mem_read[2], mem_write[2];
    logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];
    logic [31:0] mem[2][128];
    exp_t        sb[$];
    int          n_cmp = 0, n_bad = 0;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        dmem_arbiter #(.DEPTH(128), .MEM_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .m0_req   (req[g][0]),
            .m0_we    (we[g][0]),
            .m0_addr  (addr[g][0]),
            .m0_wdata (wdata[g][0]),
            .m0_rdata (rdata[g][0]),
            .m0_done  (done[g][0]),
            .m0_err   (err[g][0]),
            .m1_req   (req[g][1]),
            .m1_we    (we[g][1]),
            .m1_addr  (addr[g][1]),
            .m1_wdata (wdata[g][1]),
            .m1_rdata (rdata[g][1]),
            .m1_done  (done[g][1]),
            .m1_err   (err[g][1]),
            .mem_read (mem_read[g]),
            .mem_write(mem_write[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
        );
        assign mem_rdata[g] = mem[g][mem_addr[g][6:0]];
        always @(posedge clk) begin
            if (mem_load)
                for (int i = 0; i < 128; i++) mem[g][i] <= 32'(i * 10);
            else if (mem_write[g])
                mem[g][mem_addr[g][6:0]] <= mem_wdata[g];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input int g, input int m, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        we[g][m]    = w;
        addr[g][m]  = a;
        wdata[g][m] = d;
        req[g][m]   = 1'b1;
    endtask

    // Counts cycles from the IDLE sampling cycle (n=0) to done; lat=-1 means the budget ran out.
    task automatic wait_done(input int g, input int m, output int lat, output int rd_cyc, output int wr_cyc,
                             output logic [31:0] a0, output logic moved);
        bit first = 1;
        lat = -1; rd_cyc = 0; wr_cyc = 0; a0 = '0; moved = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_read[g] || mem_write[g]) begin
                if (first) a0 = mem_addr[g];
                else if (mem_addr[g] !== a0) moved = 1;
                first = 0;
                rd_cyc += int'(mem_read[g]);
                wr_cyc += int'(mem_write[g]);
            end
            if (done[g][m]) begin
                lat = n;
                req[g][m] = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            n_cmp++; if ({mem_read[g], mem_write[g]} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes[%0d]: got %b want 00", g, {mem_read[g], mem_write[g]}); end
            n_cmp++; if ({mem_addr[g], mem_wdata[g]} !== 64'd0) begin n_bad++; $display("FAIL reset_mem_bus[%0d]: got %h want 0", g, {mem_addr[g], mem_wdata[g]}); end
            n_cmp++; if ({done[g][0], err[g][0], done[g][1], err[g][1]} !== 4'b0) begin n_bad++; $display("FAIL reset_flags[%0d]: got %b want 0000", g, {done[g][0], err[g][0], done[g][1], err[g][1]}); end
            n_cmp++; if ({rdata[g][0], rdata[g][1]} !== 64'd0) begin n_bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", g, {rdata[g][0], rdata[g][1]}); end
        end
    endtask

    task automatic test_read();
        exp_t e; int lat, rc, wc; logic [31:0] a0; logic mv;
        sb.push_back('{g: 0, m: 0, rdata: 32'd50, err: 1'b0, lat: 2});
        issue(0, 0, 1'b0, 32'd5, 32'd0);
        wait_done(0, 0, lat, rc, wc, a0, mv);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL read_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (rdata[e.g][e.m] !== e.rdata) begin n_bad++; $display("FAIL read_rdata: got %h want %h", rdata[e.g][e.m], e.rdata); end
        n_cmp++; if (err[e.g][e.m] !== e.err) begin n_bad++; $display("FAIL read_err: got %b want %b", err[e.g][e.m], e.err); end
        n_cmp++; if (rc !== 1 || wc !== 0) begin n_bad++; $display("FAIL read_strobes: got rd=%0d wr=%0d want rd=1 wr=0", rc, wc); end
        n_cmp++; if (a0 !== 32'd5) begin n_bad++; $display("FAIL read_addr: got %h want 5", a0); end
    endtask

    task automatic test_write_read();
        exp_t e; int lat, rc, wc; logic [31:0] a0; logic mv;
        sb.push_back('{g: 0, m: 1, rdata: 32'd0, err: 1'b0, lat: 2});
        issue(0, 1, 1'b1, 32'd10, 32'hDEADBEEF);
        wait_done(0, 1, lat, rc, wc, a0, mv);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL write_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (rc !== 0 || wc !== 1) begin n_bad++; $display("FAIL write_strobes: got rd=%0d wr=%0d want rd=0 wr=1", rc, wc); end
        n_cmp++; if (err[e.g][e.m] !== e.err) begin n_bad++; $display("FAIL write_err: got %b want %b", err[e.g][e.m], e.err); end
        sb.push_back('{g: 0, m: 0, rdata: 32'hDEADBEEF, err: 1'b0, lat: 2});
        issue(0, 0, 1'b0, 32'd10, 32'd0);
        wait_done(0, 0, lat, rc, wc, a0, mv);
        e = sb.pop_front();
        n_cmp++; if (rdata[e.g][e.m] !== e.rdata) begin n_bad++; $display("FAIL readback_rdata: got %h want %h", rdata[e.g][e.m], e.rdata); end
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL readback_latency: got %0d want %0d", lat, e.lat); end
    endtask

    task automatic test_error();
        exp_t e; int lat, rc, wc; logic [31:0] a0; logic mv;
        sb.push_back('{g: 0, m: 0, rdata: 32'hDEADBEEF, err: 1'b1, lat: 1});
        sb.push_back('{g: 0, m: 1, rdata: 32'd0, err: 1'b1, lat: 1});
        issue(0, 0, 1'b0, 32'd128, 32'd0);
        wait_done(0, 0, lat, rc, wc, a0, mv);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL err128_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (err[e.g][e.m] !== e.err) begin n_bad++; $display("FAIL err128_err: got %b want %b", err[e.g][e.m], e.err); end
        n_cmp++; if (rdata[e.g][e.m] !== e.rdata) begin n_bad++; $display("FAIL err128_rdata_kept: got %h want %h", rdata[e.g][e.m], e.rdata); end
        n_cmp++; if (rc + wc !== 0) begin n_bad++; $display("FAIL err128_no_access: got %0d strobe cycles want 0", rc + wc); end
        issue(0, 1, 1'b1, 32'hFFFF_FFFF, 32'h5555_AAAA);
        wait_done(0, 1, lat, rc, wc, a0, mv);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat || err[e.g][e.m] !== e.err) begin n_bad++; $display("FAIL errmax_resp: got lat=%0d err=%b want lat=%0d err=%b", lat, err[e.g][e.m], e.lat, e.err); end
        n_cmp++; if (rc + wc !== 0) begin n_bad++; $display("FAIL errmax_no_access: got %0d strobe cycles want 0", rc + wc); end
    endtask

    task automatic test_back_to_back();
        exp_t e; int got = 0, last = -1;
        for (int k = 0; k < 4; k++)
            sb.push_back('{g: 0, m: k % 2, rdata: (k % 2) ? 32'd20 : 32'd10, err: 1'b0, lat: 0});
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        we[0][0] = 1'b0; addr[0][0] = 32'd1; req[0][0] = 1'b1;
        we[0][1] = 1'b0; addr[0][1] = 32'd2; req[0][1] = 1'b1;
        for (int n = 0; n < 40 && got < 4; n++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) if (done[0][m] && got < 4) begin
                e = sb.pop_front();
                n_cmp++; if (m !== e.m) begin n_bad++; $display("FAIL grant_order[%0d]: got m%0d want m%0d", got, m, e.m); end
                n_cmp++; if (rdata[0][m] !== e.rdata) begin n_bad++; $display("FAIL contended_rdata[%0d]: got %h want %h", got, rdata[0][m], e.rdata); end
                if (last >= 0) begin
                    n_cmp++; if (n - last !== 3) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", got, n - last); end
                end
                last = n;
                got++;
            end
        end
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
        n_cmp++; if (got !== 4) begin n_bad++; $display("FAIL contended_count: got %0d want 4", got); end
        sb.delete();
    endtask

    task automatic test_latency3();
        exp_t e; int lat, rc, wc; logic [31:0] a0; logic mv;
        sb.push_back('{g: 1, m: 1, rdata: 32'd70, err: 1'b0, lat: 4});
        issue(1, 1, 1'b0, 32'd7, 32'd0);
        wait_done(1, 1, lat, rc, wc, a0, mv);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL lat3_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (rdata[e.g][e.m] !== e.rdata) begin n_bad++; $display("FAIL lat3_rdata: got %h want %h", rdata[e.g][e.m], e.rdata); end
        n_cmp++; if (rc !== 3 || wc !== 0) begin n_bad++; $display("FAIL lat3_strobes: got rd=%0d wr=%0d want rd=3 wr=0", rc, wc); end
        n_cmp++; if (a0 !== 32'd7 || mv !== 1'b0) begin n_bad++; $display("FAIL lat3_addr_stable: got addr=%h moved=%b want 7/0", a0, mv); end
    endtask

    task automatic test_reset_mid_op();
        exp_t e; int lat, rc, wc, bad = 0; logic [31:0] a0; logic mv;
        issue(1, 0, 1'b1, 32'd20, 32'h1234_5678);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (mem_write[1] !== 1'b1) begin n_bad++; $display("FAIL midop_write_issued: got %b want 1", mem_write[1]); end
        reset = 1'b1;
        req[1][0] = 1'b0;
        @(negedge clk);
        n_cmp++; if ({mem_read[1], mem_write[1], done[1][0]} !== 3'b000) begin n_bad++; $display("FAIL midop_reset_idle: got %b want 000", {mem_read[1], mem_write[1], done[1][0]}); end
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            bad += int'(done[1][0] | mem_write[1] | mem_read[1]);
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL midop_dropped: got %0d active cycles want 0", bad); end
        n_cmp++; if (mem[1][20] !== 32'h1234_5678) begin n_bad++; $display("FAIL midop_write_kept: got %h want 12345678", mem[1][20]); end
        sb.push_back('{g: 1, m: 1, rdata: 32'd1270, err: 1'b0, lat: 4});
        issue(1, 1, 1'b0, 32'd127, 32'd0);
        wait_done(1, 1, lat, rc, wc, a0, mv);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat || err[e.g][e.m] !== e.err) begin n_bad++; $display("FAIL post_reset_resp: got lat=%0d err=%b want lat=%0d err=%b", lat, err[e.g][e.m], e.lat, e.err); end
        n_cmp++; if (rdata[e.g][e.m] !== e.rdata) begin n_bad++; $display("FAIL post_reset_rdata: got %h want %h", rdata[e.g][e.m], e.rdata); end
    endtask

    initial begin
        reset = 1'b1;
        mem_load = 1'b1;
        for (int g = 0; g < 2; g++)
            for (int m = 0; m < 2; m++) begin
                req[g][m] = 1'b0; we[g][m] = 1'b0; addr[g][m] = '0; wdata[g][m] = '0;
            end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mem_load = 1'b0;
        test_reset();
        test_read();
        test_write_read();
        test_error();
        test_back_to_back();
        test_latency3();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer for the single-port data memory.
- Master 0 is the core load/store unit; master 1 is a debug/DMA loader.
- Serialises requests with round-robin priority and drives the memory's read/write strobes, address and write data with a fixed access latency.
- Rejects out-of-range word addresses with an error response; no memory access is made for them.

Parameters:
- DEPTH, 128, number of 32-bit words in the data memory. Legal word addresses are 0..DEPTH-1.
- MEM_LAT, 1, cycles the address and strobes are held for one access (must be >=1).

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 request; held high until m0_done
- m0_we  in  1  master 0: 1=write, 0=read; stable while req high
- m0_addr  in  32  master 0 word address; stable while req high
- m0_wdata  in  32  master 0 write data; stable while req high
- m0_rdata  out  32  master 0 read data; valid when m0_done=1
- m0_done  out  1  master 0 one-cycle completion pulse
- m0_err  out  1  master 0 out-of-range flag; qualified by m0_done
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_done, m1_err  same widths and meanings for master 1
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  32  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE; mem_read=mem_write=0; mem_addr=0; mem_wdata=0.
- Reset values (per master): mX_done=0, mX_err=0, mX_rdata=0.
- Reset values (arbitration): round-robin pointer favours m0.
- IDLE:
  - If any req is high, pick the winner and latch its we/addr/wdata.
  - Single requester: that requester wins.
  - Both requesting: the master not granted last wins; the pointer then flips to the other master.
  - addr >= DEPTH: go to RESP with err=1.
  - Otherwise: go to ACCESS with the latency counter = MEM_LAT-1.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched values.
  - mem_read = !we or mem_write = we, held for all MEM_LAT cycles.
  - mem_addr does not change within an access.
  - On the last ACCESS cycle (counter==0), capture mem_rdata for reads, then go to RESP.
- RESP:
  - Winner's done=1 for exactly one cycle; err is as latched.
  - rdata holds the captured word (reads only). rdata is otherwise retained until the next read completion to that master.
  - Strobes are 0. Next state is IDLE.
- Latency:
  - Valid request sampled in IDLE at cycle 0 -> done in cycle MEM_LAT+1.
  - Error request -> done in cycle 1.
  - Back-to-back throughput: one access per MEM_LAT+2 cycles.
- Handshake:
  - A master must deassert req in the cycle after its done pulse; a req still high in IDLE is treated as a new transaction.
  - The loser's req is not acknowledged and stays pending; it is served next IDLE.
- The pointer updates only on a contested grant (both req high in IDLE).
- Errored transactions count as grants for the pointer.
- Reset mid-operation: return to IDLE immediately. The in-flight transaction is dropped, with no done and no further strobes. A write whose strobe was already issued is not undone.
- Addresses are unsigned 32-bit compares against DEPTH; no wrap-around or truncation.

Decomposition:
- Shared package holds:
  - state encoding IDLE/ACCESS/RESP
  - master-index constants M0=0, M1=1
  - default DEPTH and MEM_LAT values
- One sub-module, rr_arbiter2: combinational 2-way round-robin pick plus the registered pointer.
- FSM, latching and datapath muxing stay in dmem_arbiter.

Test Plan:
- Reset, then m0 read addr 5 (memory holds 50), MEM_LAT=1 -> mem_read high 1 cycle with mem_addr=5; m0_done in cycle 2 with m0_rdata=50, m0_err=0.
- m1 write addr 10 data 0xDEADBEEF, then m0 read addr 10 -> mem_write for 1 cycle only; m1_done; m0_rdata=0xDEADBEEF.
- m0 and m1 both request reads continuously, 4 transactions -> grants m0, m1, m0, m1; no grant starvation.
- m0 read addr 128 (DEPTH=128) -> no mem_read or mem_write; m0_done in cycle 1 with m0_err=1; m0_rdata unchanged.
- MEM_LAT=3, m1 read addr 7 -> mem_addr=7 stable and mem_read high 3 cycles; m1_done in cycle 4 with data 70.
- Assert reset during ACCESS of an m0 write -> next cycle state IDLE, strobes 0, m0_done never pulses; subsequent m1 read still serviced correctly.
